serial_sample_table: RTL and testbench

Parametrised storage for the serial-circuit evaluation samples. Each sample holds an input sequence, an expected-output sequence and a per-bit valid mask. Samples are written one at a time through the prepare/write handshake from the sample sequencer. The table tracks which entries are loaded, flags out-of-range indices, supports a timed bulk clear, and exposes a registered read port to the fitness evaluator.

---
 rtl/serial_sample_pkg.sv | 20 ++
 rtl/serial_sample_table_if.sv | 45 ++++
 rtl/serial_sample_ram.sv | 86 ++++++++
 rtl/serial_sample_table.sv | 122 ++++++++++++
 tb/tb_serial_sample_table.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sample_pkg.sv
// Shared constants, FSM encodings and the sample record type for the serial sample table.
package serial_sample_pkg;

  localparam int unsigned DefNumSamples = 16;
  localparam int unsigned DefSeqLen     = 4;
  localparam int unsigned DefWordW      = 8;
  localparam int unsigned DefDataW      = DefSeqLen * DefWordW;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaiting  = 2'd1;
  localparam logic [1:0] StClearing = 2'd2;

  // One table entry at the default geometry.
  typedef struct packed {
    logic [DefDataW-1:0] in_seq;
    logic [DefDataW-1:0] exp_seq;
    logic [DefDataW-1:0] vld_seq;
  } sample_t;

endpackage

// File: rtl/serial_sample_table_if.sv
// Sequencer/evaluator bus of the serial sample table: write handshake, clear and read port.
interface serial_sample_table_if import serial_sample_pkg::*; #(
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned SEQ_LEN     = DefSeqLen,
  parameter int unsigned WORD_W      = DefWordW
) ();

  localparam int unsigned IDX_W  = $clog2(NUM_SAMPLES);
  localparam int unsigned DATA_W = SEQ_LEN * WORD_W;

  logic                   iPreparingNextSample;
  logic                   iWriteSample;
  logic [31:0]            iSampleIndex;
  logic [DATA_W-1:0]      iCurrentSerialInput;
  logic [DATA_W-1:0]      iCurrentSerialExpectedOutput;
  logic [DATA_W-1:0]      iCurrentSerialValidOutput;
  logic                   iClearAll;
  logic [IDX_W-1:0]       iReadIndex;

  logic                   oNextSample;
  logic                   oWriteAck;
  logic                   oIndexError;
  logic [NUM_SAMPLES-1:0] oLoadedMask;
  logic [IDX_W:0]         oLoadedCount;
  logic                   oAllLoaded;
  logic [DATA_W-1:0]      oReadInput;
  logic [DATA_W-1:0]      oReadExpected;
  logic [DATA_W-1:0]      oReadValid;
  logic                   oReadLoaded;

  modport master (
    output iPreparingNextSample, iWriteSample, iSampleIndex, iCurrentSerialInput,
           iCurrentSerialExpectedOutput, iCurrentSerialValidOutput, iClearAll, iReadIndex,
    input  oNextSample, oWriteAck, oIndexError, oLoadedMask, oLoadedCount, oAllLoaded,
           oReadInput, oReadExpected, oReadValid, oReadLoaded
  );

  modport slave (
    input  iPreparingNextSample, iWriteSample, iSampleIndex, iCurrentSerialInput,
           iCurrentSerialExpectedOutput, iCurrentSerialValidOutput, iClearAll, iReadIndex,
    output oNextSample, oWriteAck, oIndexError, oLoadedMask, oLoadedCount, oAllLoaded,
           oReadInput, oReadExpected, oReadValid, oReadLoaded
  );

endinterface

// File: rtl/serial_sample_ram.sv
// Sample register file: one write port, one clear-by-index port, one registered read port,
// plus the per-entry loaded mask.
module serial_sample_ram import serial_sample_pkg::*; #(
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned DATA_W      = DefDataW,
  localparam int unsigned IDX_W      = $clog2(NUM_SAMPLES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [DATA_W-1:0]      win_i,
  input  logic [DATA_W-1:0]      wexp_i,
  input  logic [DATA_W-1:0]      wvld_i,
  input  logic                   clr_i,
  input  logic [IDX_W-1:0]       caddr_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [NUM_SAMPLES-1:0] loaded_o,
  output logic [DATA_W-1:0]      rin_o,
  output logic [DATA_W-1:0]      rexp_o,
  output logic [DATA_W-1:0]      rvld_o,
  output logic                   rloaded_o
);

  logic [DATA_W-1:0]      in_q  [NUM_SAMPLES];
  logic [DATA_W-1:0]      exp_q [NUM_SAMPLES];
  logic [DATA_W-1:0]      vld_q [NUM_SAMPLES];
  logic [NUM_SAMPLES-1:0] mask_q;

  logic [DATA_W-1:0] rin_q, rexp_q, rvld_q;
  logic              rloaded_q;
  logic              raddr_ok;

  assign raddr_ok = 32'(raddr_i) < NUM_SAMPLES;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
        in_q[i]  <= '0;
        exp_q[i] <= '0;
        vld_q[i] <= '0;
      end
      mask_q <= '0;
    end else begin
      if (we_i) begin
        in_q[waddr_i]   <= win_i;
        exp_q[waddr_i]  <= wexp_i;
        vld_q[waddr_i]  <= wvld_i;
        mask_q[waddr_i] <= 1'b1;
      end
      if (clr_i) begin
        in_q[caddr_i]   <= '0;
        exp_q[caddr_i]  <= '0;
        vld_q[caddr_i]  <= '0;
        mask_q[caddr_i] <= 1'b0;
      end
    end
  end

  // Read samples the array before this edge's write/clear takes effect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rin_q     <= '0;
      rexp_q    <= '0;
      rvld_q    <= '0;
      rloaded_q <= 1'b0;
    end else if (raddr_ok) begin
      rin_q     <= in_q[raddr_i];
      rexp_q    <= exp_q[raddr_i];
      rvld_q    <= vld_q[raddr_i];
      rloaded_q <= mask_q[raddr_i];
    end else begin
      rin_q     <= '0;
      rexp_q    <= '0;
      rvld_q    <= '0;
      rloaded_q <= 1'b0;
    end
  end

  assign loaded_o  = mask_q;
  assign rin_o     = rin_q;
  assign rexp_o    = rexp_q;
  assign rvld_o    = rvld_q;
  assign rloaded_o = rloaded_q;

endmodule

// File: rtl/serial_sample_table.sv
// Serial sample table: write handshake FSM, loaded count/flags and timed bulk clear
// around the sample register file.
module serial_sample_table import serial_sample_pkg::*; #(
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned SEQ_LEN     = DefSeqLen,
  parameter int unsigned WORD_W      = DefWordW
) (
  input logic                  iClock,
  input logic                  iReset,
  serial_sample_table_if.slave tbl_io
);

  localparam int unsigned IDX_W  = $clog2(NUM_SAMPLES);
  localparam int unsigned DATA_W = SEQ_LEN * WORD_W;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic                   we;
  logic                   clr;
  logic                   idx_ok;
  logic [IDX_W-1:0]       waddr;
  logic [NUM_SAMPLES-1:0] mask;

  // All 32 index bits take part, so aliases of legal indices are rejected.
  assign idx_ok = tbl_io.iSampleIndex < NUM_SAMPLES;
  assign waddr  = tbl_io.iSampleIndex[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    count_d   = count_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    we        = 1'b0;
    clr       = 1'b0;
    case (state_q)
      StIdle: begin
        if (tbl_io.iClearAll) begin
          state_d   = StClearing;
          clr_cnt_d = '0;
        end else if (tbl_io.iPreparingNextSample) begin
          state_d = StWaiting;
        end
      end
      StWaiting: begin
        if (tbl_io.iClearAll) begin
          state_d   = StClearing;
          clr_cnt_d = '0;
        end else if (tbl_io.iWriteSample) begin
          if (idx_ok) begin
            we    = 1'b1;
            ack_d = 1'b1;
            if (!mask[waddr]) count_d = count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      StClearing: begin
        clr = 1'b1;
        if (mask[clr_cnt_q]) count_d = count_q - 1'b1;
        if (clr_cnt_q == IDX_W'(NUM_SAMPLES - 1)) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  serial_sample_ram #(
    .NUM_SAMPLES(NUM_SAMPLES),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk_i    (iClock),
    .rst_i    (iReset),
    .we_i     (we),
    .waddr_i  (waddr),
    .win_i    (tbl_io.iCurrentSerialInput),
    .wexp_i   (tbl_io.iCurrentSerialExpectedOutput),
    .wvld_i   (tbl_io.iCurrentSerialValidOutput),
    .clr_i    (clr),
    .caddr_i  (clr_cnt_q),
    .raddr_i  (tbl_io.iReadIndex),
    .loaded_o (mask),
    .rin_o    (tbl_io.oReadInput),
    .rexp_o   (tbl_io.oReadExpected),
    .rvld_o   (tbl_io.oReadValid),
    .rloaded_o(tbl_io.oReadLoaded)
  );

  assign tbl_io.oNextSample  = (state_q == StIdle);
  assign tbl_io.oWriteAck    = ack_q;
  assign tbl_io.oIndexError  = err_q;
  assign tbl_io.oLoadedMask  = mask;
  assign tbl_io.oLoadedCount = count_q;
  assign tbl_io.oAllLoaded   = (count_q == (IDX_W + 1)'(NUM_SAMPLES));

endmodule

// File: tb/tb_serial_sample_table.sv
// Bench for serial_sample_table: behavioural table model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_serial_sample_table;
  import serial_sample_pkg::*;

  localparam int N = 16;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CLR = 2;

  logic iClock = 1'b0;
  logic iReset = 1'b1;

  serial_sample_table_if #(.NUM_SAMPLES(N), .SEQ_LEN(4), .WORD_W(8)) tbl ();

  serial_sample_table #(.NUM_SAMPLES(N), .SEQ_LEN(4), .WORD_W(8)) dut (
    .iClock(iClock),
    .iReset(iReset),
    .tbl_io(tbl)
  );

  always #5 iClock = ~iClock;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  // Model state
  sample_t     mmem [N];
  logic [N-1:0] mmask;
  int          mmode;
  int          sweep;
  logic [31:0] exp_rin, exp_rexp, exp_rvld;
  logic        exp_rld, exp_ack, exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mmem[i] = '0;
    mmask = '0;
    mmode = M_IDLE;
    sweep = 0;
    exp_rin = '0; exp_rexp = '0; exp_rvld = '0;
    exp_rld = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_step();
    int unsigned rd;
    rd = int'(tbl.iReadIndex);
    exp_rin  = mmem[rd].in_seq;
    exp_rexp = mmem[rd].exp_seq;
    exp_rvld = mmem[rd].vld_seq;
    exp_rld  = mmask[rd];
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    if (mmode == M_CLR) begin
      mmem[sweep]  = '0;
      mmask[sweep] = 1'b0;
      sweep++;
      if (sweep == N) mmode = M_IDLE;
    end else if (tbl.iClearAll) begin
      mmode = M_CLR;
      sweep = 0;
    end else if (mmode == M_IDLE) begin
      if (tbl.iPreparingNextSample) mmode = M_WAIT;
    end else if (tbl.iWriteSample) begin
      if (tbl.iSampleIndex < 32'(N)) begin
        mmem[tbl.iSampleIndex].in_seq  = tbl.iCurrentSerialInput;
        mmem[tbl.iSampleIndex].exp_seq = tbl.iCurrentSerialExpectedOutput;
        mmem[tbl.iSampleIndex].vld_seq = tbl.iCurrentSerialValidOutput;
        mmask[tbl.iSampleIndex] = 1'b1;
        exp_ack = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      mmode = M_IDLE;
    end
  endtask

  always @(posedge iClock) if (!iReset) model_step();

  always @(negedge iClock) begin
    if (run_cmp) begin
      check("next",  64'(tbl.oNextSample),  64'(mmode == M_IDLE));
      check("ack",   64'(tbl.oWriteAck),    64'(exp_ack));
      check("err",   64'(tbl.oIndexError),  64'(exp_err));
      check("mask",  64'(tbl.oLoadedMask),  64'(mmask));
      check("count", 64'(tbl.oLoadedCount), 64'($countones(mmask)));
      check("all",   64'(tbl.oAllLoaded),   64'($countones(mmask) == N));
      check("rin",   64'(tbl.oReadInput),   64'(exp_rin));
      check("rexp",  64'(tbl.oReadExpected), 64'(exp_rexp));
      check("rvld",  64'(tbl.oReadValid),   64'(exp_rvld));
      check("rld",   64'(tbl.oReadLoaded),  64'(exp_rld));
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!tbl.oNextSample && t < 64) begin
      @(negedge iClock);
      t++;
    end
    if (!tbl.oNextSample) check("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_write(input logic [31:0] idx, input logic [31:0] din,
                          input logic [31:0] dexp, input logic [31:0] dvld);
    wait_idle();
    tbl.iPreparingNextSample = 1'b1;
    @(negedge iClock);
    tbl.iPreparingNextSample = 1'b0;
    tbl.iWriteSample = 1'b1;
    tbl.iSampleIndex = idx;
    tbl.iCurrentSerialInput = din;
    tbl.iCurrentSerialExpectedOutput = dexp;
    tbl.iCurrentSerialValidOutput = dvld;
    @(negedge iClock);
    tbl.iWriteSample = 1'b0;
  endtask

  initial begin
    int lows;
    int r;
    tbl.iPreparingNextSample = 1'b0;
    tbl.iWriteSample = 1'b0;
    tbl.iSampleIndex = '0;
    tbl.iCurrentSerialInput = '0;
    tbl.iCurrentSerialExpectedOutput = '0;
    tbl.iCurrentSerialValidOutput = '0;
    tbl.iClearAll = 1'b0;
    tbl.iReadIndex = 4'd3;
    model_reset();
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    run_cmp = 1'b1;
    @(negedge iClock);
    check("rst_next",  64'(tbl.oNextSample), 64'(1));
    check("rst_count", 64'(tbl.oLoadedCount), 64'(0));
    check("rst_mask",  64'(tbl.oLoadedMask), 64'(0));
    check("rst_rd3",   64'(tbl.oReadInput), 64'(0));
    check("rst_rld3",  64'(tbl.oReadLoaded), 64'(0));

    do_write(32'd5, 32'hA1B2C3D4, 32'h0F0F0F0F, 32'hFFFF00FF);
    check("w5_ack",   64'(tbl.oWriteAck), 64'(1));
    check("w5_mask",  64'(tbl.oLoadedMask), 64'h0020);
    check("w5_count", 64'(tbl.oLoadedCount), 64'(1));
    tbl.iReadIndex = 4'd5;
    @(negedge iClock);
    check("w5_ack_end", 64'(tbl.oWriteAck), 64'(0));
    check("r5_in",  64'(tbl.oReadInput), 64'hA1B2C3D4);
    check("r5_exp", 64'(tbl.oReadExpected), 64'h0F0F0F0F);
    check("r5_vld", 64'(tbl.oReadValid), 64'hFFFF00FF);
    check("r5_ld",  64'(tbl.oReadLoaded), 64'(1));

    do_write(32'd5, 32'h11111111, 32'h0F0F0F0F, 32'hFFFF00FF);
    @(negedge iClock);
    check("ow_in",    64'(tbl.oReadInput), 64'h11111111);
    check("ow_count", 64'(tbl.oLoadedCount), 64'(1));

    do_write(32'd16, 32'h22222222, 32'h0, 32'h0);
    check("e16_err",  64'(tbl.oIndexError), 64'(1));
    check("e16_ack",  64'(tbl.oWriteAck), 64'(0));
    check("e16_mask", 64'(tbl.oLoadedMask), 64'h0020);

    for (int i = 0; i < N; i++) do_write(32'(i), $urandom, $urandom, $urandom);
    check("all_loaded", 64'(tbl.oAllLoaded), 64'(1));

    // Clear wins over a simultaneous write in WAITING.
    wait_idle();
    tbl.iPreparingNextSample = 1'b1;
    @(negedge iClock);
    tbl.iPreparingNextSample = 1'b0;
    tbl.iWriteSample = 1'b1;
    tbl.iClearAll = 1'b1;
    tbl.iSampleIndex = 32'd2;
    @(negedge iClock);
    tbl.iWriteSample = 1'b0;
    tbl.iClearAll = 1'b0;
    check("clr_drop_ack", 64'(tbl.oWriteAck), 64'(0));
    lows = tbl.oNextSample ? 0 : 1;
    for (int k = 0; k < 40 && !tbl.oNextSample; k++) begin
      @(negedge iClock);
      if (!tbl.oNextSample) lows++;
      if (lows == 9) check("clr_mid_count", 64'(tbl.oLoadedCount), 64'(8));
    end
    check("clr_low_cycles", 64'(lows), 64'(16));
    check("clr_count", 64'(tbl.oLoadedCount), 64'(0));

    // Reset in the middle of a sweep.
    for (int i = 0; i < N; i++) do_write(32'(i), $urandom, $urandom, $urandom);
    wait_idle();
    tbl.iClearAll = 1'b1;
    @(negedge iClock);
    tbl.iClearAll = 1'b0;
    repeat (7) @(negedge iClock);
    check("sweep7_count", 64'(tbl.oLoadedCount), 64'(9));
    #2;
    iReset = 1'b1;
    model_reset();
    #1;
    check("arst_count", 64'(tbl.oLoadedCount), 64'(0));
    check("arst_mask",  64'(tbl.oLoadedMask), 64'(0));
    check("arst_next",  64'(tbl.oNextSample), 64'(1));
    check("arst_rin",   64'(tbl.oReadInput), 64'(0));
    check("arst_rld",   64'(tbl.oReadLoaded), 64'(0));
    @(negedge iClock);
    iReset = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(negedge iClock);
      tbl.iPreparingNextSample = 1'($urandom_range(0, 1));
      tbl.iWriteSample = ($urandom_range(0, 2) == 0);
      tbl.iClearAll = ($urandom_range(0, 59) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 8) tbl.iSampleIndex = $urandom_range(0, 15);
      else if (r == 8) tbl.iSampleIndex = 32'd16 + $urandom_range(0, 3);
      else tbl.iSampleIndex = $urandom;
      tbl.iCurrentSerialInput = $urandom;
      tbl.iCurrentSerialExpectedOutput = $urandom;
      tbl.iCurrentSerialValidOutput = $urandom;
      tbl.iReadIndex = 4'($urandom_range(0, 15));
    end
    @(negedge iClock);
    tbl.iPreparingNextSample = 1'b0;
    tbl.iWriteSample = 1'b0;
    tbl.iClearAll = 1'b0;
    repeat (2) @(negedge iClock);
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
